serial_add_ctrl: RTL and testbench

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/serial_add_ctrl.sv | 122 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder step per clock, LSB first, IDLE/RUN/DONE control.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       fa_res;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  // Returns {carry_out, sum_bit}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
    full_add = {(x & y) | (c & (x ^ y)), x ^ y ^ c};
  endfunction

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    fa_res  = full_add(a_q[0], b_q[0], carry_q);
`ifdef SERIAL_ADD_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        sum_d   = {fa_res[0], sum_q[WIDTH-1:1]};
        carry_d = fa_res[1];
        if (cnt_q == LAST) begin
          // Counter parks on the last index so it never wraps mid-operation.
          cout_d  = fa_res[1];
`ifdef SERIAL_ADD_OVF_EN
          ovf_d   = carry_q ^ fa_res[1];
`endif
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl (WIDTH=8); overflow checks only when SERIAL_ADD_OVF_EN is defined.
module tb_serial_add_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n, start, cin;
  logic [W-1:0] a, b, sum;
  logic         busy, done, cout;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
`ifdef SERIAL_ADD_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   done_cnt = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    logic [W:0] t;
    exp_t e;
    t   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    e.s = t[W-1:0];
    e.c = t[W];
    e.o = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
    return e;
  endfunction

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (done !== 1'b1 && n < 40);
    if (done !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL done_timeout: done=%b after %0d cycles, required 1", done, n);
    end
  endtask

  task automatic check_result(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_scoreboard: queue empty at done, required an entry", name);
    end else begin
      e = sb.pop_front();
      n_cmp++;
      if (sum !== e.s) begin
        n_bad++; $display("FAIL %s_sum: got %h required %h", name, sum, e.s);
      end
      n_cmp++;
      if (cout !== e.c) begin
        n_bad++; $display("FAIL %s_cout: got %b required %b", name, cout, e.c);
      end
`ifdef SERIAL_ADD_OVF_EN
      n_cmp++;
      if (ovf !== e.o) begin
        n_bad++; $display("FAIL %s_ovf: got %b required %b", name, ovf, e.o);
      end
`endif
    end
  endtask

  task automatic run_op(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic ci);
    int m;
    a = x; b = y; cin = ci; start = 1'b1;
    sb.push_back(model(x, y, ci));
    @(posedge clk); #1;
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++; $display("FAIL %s_busy_run: got %b required 1", name, busy);
    end
    wait_done(m);
    n_cmp++;
    if (m + 1 != W + 1) begin
      n_bad++; $display("FAIL %s_latency: got %0d cycles required %0d", name, m + 1, W + 1);
    end
    check_result(name);
    @(posedge clk); #1;
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL %s_idle: done=%b busy=%b required 0/0", name, done, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, sum, cout} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: busy=%b done=%b sum=%h cout=%b required all 0", busy, done, sum, cout);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [W-1:0] ta[6] = '{8'h00, 8'hFF, 8'hA5, 8'h12, 8'h80, 8'h3C};
    logic [W-1:0] tb[6] = '{8'h00, 8'h01, 8'h5A, 8'h34, 8'h7F, 8'hC3};
    logic         tc[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) run_op($sformatf("basic%0d", i), ta[i], tb[i], tc[i]);
  endtask

`ifdef SERIAL_ADD_OVF_EN
  task automatic test_ovf();
    run_op("ovf_pos", 8'h7F, 8'h01, 1'b0);
    run_op("ovf_neg", 8'h80, 8'h80, 1'b0);
    run_op("ovf_none", 8'h40, 8'h20, 1'b0);
  endtask
`endif

  task automatic test_ignore_start();
    int base, m;
    base = done_cnt;
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    sb.push_back(model(8'h12, 8'h34, 1'b0));
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = 8'h55; b = 8'hAA;
    wait_done(m);
    check_result("ignore");
    repeat (W + 4) begin @(posedge clk); #1; end
    n_cmp++;
    if (done_cnt - base != 1 || busy !== 1'b0) begin
      n_bad++; $display("FAIL ignore_single: done pulses=%0d busy=%b required 1/0", done_cnt - base, busy);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    base = done_cnt;
    a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, sum, cout} !== '0) begin
      n_bad++;
      $display("FAIL midreset_outputs: busy=%b done=%b sum=%h cout=%b required all 0", busy, done, sum, cout);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (W + 2) begin @(posedge clk); #1; end
    n_cmp++;
    if (done_cnt != base || busy !== 1'b0) begin
      n_bad++; $display("FAIL midreset_no_done: pulses=%0d busy=%b required 0/0", done_cnt - base, busy);
    end
    run_op("after_reset", 8'h03, 8'h04, 1'b1);
  endtask

  task automatic test_back_to_back();
    int t[3];
    int m;
    logic [W-1:0] x, y;
    logic ci;
    x = W'($urandom); y = W'($urandom); ci = 1'($urandom);
    a = x; b = y; cin = ci; start = 1'b1;
    sb.push_back(model(x, y, ci));
    for (int i = 0; i < 3; i++) begin
      wait_done(m);
      t[i] = cyc;
      check_result($sformatf("b2b%0d", i));
      if (i < 2) begin
        x = W'($urandom); y = W'($urandom); ci = 1'($urandom);
        a = x; b = y; cin = ci;
        sb.push_back(model(x, y, ci));
      end else begin
        start = 1'b0;
      end
    end
    for (int i = 1; i < 3; i++) begin
      n_cmp++;
      if (t[i] - t[i-1] != W + 2) begin
        n_bad++; $display("FAIL b2b_spacing%0d: got %0d cycles required %0d", i, t[i] - t[i-1], W + 2);
      end
    end
    repeat (3) begin @(posedge clk); #1; end
    n_cmp++;
    if (busy !== 1'b0 || sb.size() != 0) begin
      n_bad++; $display("FAIL b2b_drain: busy=%b pending=%0d required 0/0", busy, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
`ifdef SERIAL_ADD_OVF_EN
    test_ovf();
`endif
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
